scoreboard_regfile: RTL and testbench
=====================================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter DataWidth, default 16, register data width.
REQ-002 SHALL have parameter RegAddrBits, default 3, register address width; TotalReg = 2**RegAddrBits.
REQ-003 SHALL have parameter NumReadPorts, default 2, number of source-operand read ports, range 1..4.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port CLK, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port issue_valid, input, 1, decode-stage instruction presented.
REQ-008 SHALL have port issue_rd, input, RegAddrBits, destination of the issuing instruction.
REQ-009 SHALL have port issue_rs, input, NumReadPorts*RegAddrBits, source addresses; port i occupies bits [i*RegAddrBits +: RegAddrBits].
REQ-010 SHALL have port rd_data, output, NumReadPorts*DataWidth, source operand values, packed like issue_rs.
REQ-011 SHALL have port stall, output, 1, issue blocked this cycle.
REQ-012 SHALL have port wb_valid, input, 1, writeback strobe.
REQ-013 SHALL have port wb_rd, input, RegAddrBits, writeback destination.
REQ-014 SHALL have port wb_data, input, DataWidth, writeback value.
REQ-015 SHALL have port busy_count, output, RegAddrBits+1, number of registers with a pending write.
REQ-016 SHALL have port inr, input, RegAddrBits, debug register select.
REQ-017 SHALL have port out_value, output, DataWidth, debug register contents.

Function
REQ-018 SHALL hardwire register 0: reads return 0, writes are ignored, and it is never marked busy.
REQ-019 SHALL write wb_data into register wb_rd on the rising edge when wb_valid=1.
REQ-020 SHALL produce rd_data and out_value combinationally; out_value = stored reg[inr] and never bypassed.
REQ-021 SHALL set busy[issue_rd] on the edge where issue_valid=1, stall=0 and issue_rd!=0.
REQ-022 SHALL clear busy[wb_rd] on the edge where wb_valid=1; writeback to a non-busy register still writes the data.
REQ-023 SHALL give set priority when set and clear target the same register in one cycle (the new producer wins).
REQ-024 SHALL assert stall when issue_valid=1 and any issue_rs[i] (RAW) or issue_rd (WAW) is busy and not resolved this cycle per REQ-030/031.
REQ-025 SHALL hold stall=0 whenever issue_valid=0.
REQ-026 SHALL keep busy_count equal to the population count of busy bits, updated on the same edge as the busy bits.

Reset
REQ-027 SHALL, on RST=0, asynchronously clear all registers to 0 and all busy bits to 0, giving stall=0 and busy_count=0.
REQ-028 SHALL, when reset is asserted mid-operation, discard the in-flight writeback and issue of that cycle.
REQ-029 SHALL resume normal operation on the first rising edge after RST returns to 1.

Configuration
REQ-030 SHALL, with SB_BYPASS_EN defined, forward wb_data to rd_data[i] when wb_valid=1, wb_rd=issue_rs[i] and wb_rd!=0, and treat that register as not busy for stall in the same cycle.
REQ-031 SHALL, without SB_BYPASS_EN, return stored values only and keep stall asserted until the cycle after the writeback edge.

Structure
REQ-032 SHALL place DataWidth/RegAddrBits defaults and the register-address type in a shared package, sb_pkg.
REQ-033 SHALL implement the busy-bit vector and busy_count in one sub-module, sb_busy_tracker; storage and bypass muxes stay in the top level.

Verification
REQ-034 SHALL verify reset: RST=0 for 10 ns -> every out_value (inr 0..7) = 0x0000, busy_count = 0, stall = 0.
REQ-035 SHALL verify RAW stall: issue rd=5 (from ADDI $5,$0,2), next cycle issue rs=5,5 rd=6 -> stall = 1 until wb_rd=5 wb_data=0x0002; with SB_BYPASS_EN, stall drops in the writeback cycle and rd_data = 0x0002/0x0002.
REQ-036 SHALL verify the program sequence ADDI/ADD/ADD: after all writebacks, inr=5/6/7 -> out_value 0x0002/0x0004/0x0006, busy_count = 0.
REQ-037 SHALL verify register 0: wb_rd=0 wb_data=0xFFFF, then issue rd=0 -> out_value(inr=0) = 0x0000, busy_count unchanged, stall = 0.
REQ-038 SHALL verify simultaneous set/clear: issue rd=3 while wb_rd=3 in the same cycle -> busy[3] stays 1, busy_count unchanged, the next issue with rs=3 stalls.
REQ-039 SHALL verify WAW and mid-op reset: busy rd=4 and issue rd=4 -> stall = 1; assert RST=0 mid-stall -> stall = 0 and busy_count = 0 immediately.

Source files
------------

// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
//   Shared definitions for the scoreboarded register file.
//   - SB_DATA_W    : default register data width
//   - SB_ADDR_BITS : default register address width (8 registers)
//   - reg_addr_t   : register-address type at the default width
// -----------------------------------------------------------------------------
package sb_pkg;
  localparam int SB_DATA_W    = 16;
  localparam int SB_ADDR_BITS = 3;

  typedef logic [SB_ADDR_BITS-1:0] reg_addr_t;
endpackage

// File: rtl/sb_busy_tracker.sv
// -----------------------------------------------------------------------------
// sb_busy_tracker
//   Holds one busy bit per architectural register (a write is pending) and a
//   population count of those bits. Both update on the same clock edge.
//   Ports:
//     CLK, RST            clock, asynchronous active-low reset
//     set_en, set_addr    mark a register busy (accepted issue)
//     clr_en, clr_addr    clear a register's busy bit (writeback)
//     busy                busy vector, bit 0 is always 0
//     busy_count          number of set busy bits
// -----------------------------------------------------------------------------
module sb_busy_tracker
  import sb_pkg::*;
#(
  parameter int RegAddrBits = SB_ADDR_BITS,
  localparam int TotalReg   = 2**RegAddrBits
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   set_en,
  input  logic [RegAddrBits-1:0] set_addr,
  input  logic                   clr_en,
  input  logic [RegAddrBits-1:0] clr_addr,
  output logic [TotalReg-1:0]    busy,
  output logic [RegAddrBits:0]   busy_count
);

  logic [TotalReg-1:0]  busy_next;
  logic [RegAddrBits:0] count_next;

  // Clear first, then set: a new producer issued in the same cycle as the
  // previous producer's writeback keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
    count_next = '0;
    for (int i = 0; i < TotalReg; i++) begin
      count_next = count_next + (RegAddrBits+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile
//   Register file with a busy-bit scoreboard for an in-order issue stage.
//   Register 0 reads as zero, ignores writes and is never busy. Issue stalls
//   on RAW (a source is busy) or WAW (the destination is busy).
//   Optional macro SB_BYPASS_EN: forward the writeback value to matching
//   source ports and treat the written register as free in that cycle.
//   Ports:
//     CLK, RST                       clock, asynchronous active-low reset
//     issue_valid/issue_rd/issue_rs  decode-stage instruction
//     rd_data                        source operands, packed like issue_rs
//     stall                          issue blocked this cycle
//     wb_valid/wb_rd/wb_data         writeback strobe, address, value
//     busy_count                     number of registers pending a write
//     inr/out_value                  debug read of stored contents (no bypass)
// -----------------------------------------------------------------------------
module scoreboard_regfile
  import sb_pkg::*;
#(
  parameter int DataWidth    = SB_DATA_W,
  parameter int RegAddrBits  = SB_ADDR_BITS,
  parameter int NumReadPorts = 2
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                issue_valid,
  input  logic [RegAddrBits-1:0]              issue_rd,
  input  logic [NumReadPorts*RegAddrBits-1:0] issue_rs,
  output logic [NumReadPorts*DataWidth-1:0]   rd_data,
  output logic                                stall,
  input  logic                                wb_valid,
  input  logic [RegAddrBits-1:0]              wb_rd,
  input  logic [DataWidth-1:0]                wb_data,
  output logic [RegAddrBits:0]                busy_count,
  input  logic [RegAddrBits-1:0]              inr,
  output logic [DataWidth-1:0]                out_value
);

  localparam int TotalReg = 2**RegAddrBits;

  logic [DataWidth-1:0] regs [TotalReg];
  logic [TotalReg-1:0]  busy;
  logic [TotalReg-1:0]  resolved;
  logic [TotalReg-1:0]  eff_busy;
  logic                 wb_live;
  logic                 set_en;

  assign wb_live = wb_valid && (wb_rd != '0);

  // Registers whose pending write lands this cycle and may be consumed now.
`ifdef SB_BYPASS_EN
  always_comb begin
    resolved = '0;
    if (wb_live) resolved[wb_rd] = 1'b1;
  end
`else
  assign resolved = '0;
`endif

  assign eff_busy = busy & ~resolved;

  always_comb begin
    logic hazard;
    hazard = eff_busy[issue_rd];
    for (int i = 0; i < NumReadPorts; i++) begin
      hazard = hazard | eff_busy[issue_rs[i*RegAddrBits +: RegAddrBits]];
    end
    stall = issue_valid & hazard;
  end

  always_comb begin
    logic [RegAddrBits-1:0] a;
    rd_data = '0;
    for (int i = 0; i < NumReadPorts; i++) begin
      a = issue_rs[i*RegAddrBits +: RegAddrBits];
      rd_data[i*DataWidth +: DataWidth] = regs[a];
`ifdef SB_BYPASS_EN
      if (wb_live && (wb_rd == a)) rd_data[i*DataWidth +: DataWidth] = wb_data;
`endif
    end
  end

  assign out_value = regs[inr];

  // Register 0 is only ever reset, so it reads as zero everywhere.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < TotalReg; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign set_en = issue_valid && !stall && (issue_rd != '0);

  sb_busy_tracker #(
    .RegAddrBits (RegAddrBits)
  ) u_busy (
    .CLK        (CLK),
    .RST        (RST),
    .set_en     (set_en),
    .set_addr   (issue_rd),
    .clr_en     (wb_valid),
    .clr_addr   (wb_rd),
    .busy       (busy),
    .busy_count (busy_count)
  );

endmodule

// File: tb/tb_scoreboard_regfile.sv
module tb_scoreboard_regfile;
  import sb_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic [5:0]  issue_rs;
  logic [31:0] rd_data;
  logic        stall;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [3:0]  busy_count;
  logic [2:0]  inr;
  logic [15:0] out_value;

  always #5 CLK = ~CLK;

  scoreboard_regfile #(
    .DataWidth    (16),
    .RegAddrBits  (3),
    .NumReadPorts (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs    (issue_rs),
    .rd_data     (rd_data),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy_count  (busy_count),
    .inr         (inr),
    .out_value   (out_value)
  );

`ifdef SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: architectural register values and pending-write flags.
  logic [15:0] m_regs [8];
  bit          m_busy [8];

  typedef struct {
    bit          iv;
    int          ird, rs0, rs1;
    bit          wv;
    int          wrd;
    logic [15:0] wd;
    int          ir;
    bit          e_stall;
    int          e_bc;
    logic [15:0] e_out;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [7];

  function automatic bit resolved_now(input int a);
    return BYP && wb_valid && (int'(wb_rd) == a) && (a != 0);
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    if (m_busy[issue_rd] && !resolved_now(int'(issue_rd))) return 1'b1;
    for (int i = 0; i < 2; i++) begin
      int a;
      a = int'(issue_rs[i*3 +: 3]);
      if (m_busy[a] && !resolved_now(a)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_read(input int a);
    if (resolved_now(a)) return wb_data;
    return m_regs[a];
  endfunction

  function automatic int m_count();
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0000;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit iv, input int ird, input int rs0, input int rs1,
                       input bit wv, input int wrd, input logic [15:0] wd, input int ir);
    issue_valid = iv;
    issue_rd    = 3'(ird);
    issue_rs    = {3'(rs1), 3'(rs0)};
    wb_valid    = wv;
    wb_rd       = 3'(wrd);
    wb_data     = wd;
    inr         = 3'(ir);
    #1;
  endtask

  task automatic check_model();
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("busy_count", 32'(busy_count), 32'(m_count()));
    chk("out_value", 32'(out_value), 32'(m_regs[inr]));
    chk("rd_data", rd_data, {m_read(int'(issue_rs[5:3])), m_read(int'(issue_rs[2:0]))});
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    bit          st, iv, wv;
    int          ird, wrd;
    logic [15:0] wd;
    st  = m_stall();
    iv  = issue_valid;
    ird = int'(issue_rd);
    wv  = wb_valid;
    wrd = int'(wb_rd);
    wd  = wb_data;
    @(posedge CLK);
    if (RST) begin
      if (wv && wrd != 0) m_regs[wrd] = wd;
      if (wv) m_busy[wrd] = 1'b0;
      if (iv && !st && ird != 0) m_busy[ird] = 1'b1;
    end
    #1;
  endtask

  initial begin
    // ADDI $5,$0,2 ; ADD $6,$5,$5 ; ADD $7,$5,$6 with writebacks in between
    tbl[0] = '{1'b1, 5, 0, 0, 1'b0, 0, 16'h0000, 5, 1'b0, 0, 16'h0000, 32'h0000_0000};
    tbl[1] = '{1'b0, 0, 0, 0, 1'b1, 5, 16'h0002, 5, 1'b0, 1, 16'h0000, 32'h0000_0000};
    tbl[2] = '{1'b1, 6, 5, 5, 1'b0, 0, 16'h0000, 5, 1'b0, 0, 16'h0002, 32'h0002_0002};
    tbl[3] = '{1'b0, 0, 5, 5, 1'b1, 6, 16'h0004, 6, 1'b0, 1, 16'h0000, 32'h0002_0002};
    tbl[4] = '{1'b1, 7, 5, 6, 1'b0, 0, 16'h0000, 6, 1'b0, 0, 16'h0004, 32'h0004_0002};
    tbl[5] = '{1'b0, 0, 5, 6, 1'b1, 7, 16'h0006, 7, 1'b0, 1, 16'h0000, 32'h0004_0002};
    tbl[6] = '{1'b0, 0, 7, 0, 1'b0, 0, 16'h0000, 7, 1'b0, 0, 16'h0006, 32'h0000_0006};

    // Reset: hold RST low and sweep the debug port.
    RST = 1'b0;
    model_reset();
    drive(1'b0, 0, 0, 0, 1'b0, 0, 16'h0000, 0);
    #9;
    for (int i = 0; i < 8; i++) begin
      inr = 3'(i);
      #1;
      chk($sformatf("reset_out_value[%0d]", i), 32'(out_value), 32'h0000);
    end
    chk("reset_busy_count", 32'(busy_count), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Table-driven program sequence.
    for (int v = 0; v < 7; v++) begin
      drive(tbl[v].iv, tbl[v].ird, tbl[v].rs0, tbl[v].rs1,
            tbl[v].wv, tbl[v].wrd, tbl[v].wd, tbl[v].ir);
      check_model();
      chk($sformatf("tbl%0d_stall", v), 32'(stall), 32'(tbl[v].e_stall));
      chk($sformatf("tbl%0d_busy_count", v), 32'(busy_count), 32'(tbl[v].e_bc));
      chk($sformatf("tbl%0d_out_value", v), 32'(out_value), 32'(tbl[v].e_out));
      chk($sformatf("tbl%0d_rd_data", v), rd_data, tbl[v].e_rd);
      tick();
    end

    // RAW: rd=5 issued, dependent rs=5,5 rd=6 waits for the writeback.
    drive(1'b1, 5, 0, 0, 1'b0, 0, 16'h0000, 5);
    check_model();
    tick();
    drive(1'b1, 6, 5, 5, 1'b0, 0, 16'h0000, 5);
    check_model();
    chk("raw_stall_pending", 32'(stall), 32'd1);
    tick();
    drive(1'b1, 6, 5, 5, 1'b0, 0, 16'h0000, 5);
    chk("raw_stall_pending2", 32'(stall), 32'd1);
    tick();
    drive(1'b1, 6, 5, 5, 1'b1, 5, 16'h0002, 5);
    check_model();
    chk("raw_stall_wb_cycle", 32'(stall), BYP ? 32'd0 : 32'd1);
    chk("raw_rd_data_wb_cycle", rd_data, 32'h0002_0002);
    tick();
    if (!BYP) begin
      drive(1'b1, 6, 5, 5, 1'b0, 0, 16'h0000, 5);
      check_model();
      chk("raw_stall_after_wb", 32'(stall), 32'd0);
      chk("raw_rd_data_after_wb", rd_data, 32'h0002_0002);
      tick();
    end
    drive(1'b0, 0, 0, 0, 1'b1, 6, 16'h0004, 6);
    check_model();
    tick();
    drive(1'b0, 0, 0, 0, 1'b0, 0, 16'h0000, 6);
    check_model();
    chk("raw_end_busy_count", 32'(busy_count), 32'd0);
    tick();

    // Register 0: write attempt and issue to r0 leave no trace.
    drive(1'b0, 0, 0, 0, 1'b1, 0, 16'hFFFF, 0);
    check_model();
    tick();
    drive(1'b1, 0, 0, 0, 1'b0, 0, 16'h0000, 0);
    check_model();
    chk("r0_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0, 0, 16'h0000, 0);
    chk("r0_out_value", 32'(out_value), 32'h0000);
    chk("r0_busy_count", 32'(busy_count), 32'd0);
    chk("r0_rd_data", rd_data, 32'h0000_0000);
    tick();

    // Simultaneous set/clear on r3: the new producer wins.
    drive(1'b1, 3, 0, 0, 1'b1, 3, 16'h0033, 3);
    check_model();
    chk("simul_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 2, 3, 0, 1'b0, 0, 16'h0000, 3);
    check_model();
    chk("simul_busy_count", 32'(busy_count), 32'd1);
    chk("simul_next_stall", 32'(stall), 32'd1);
    chk("simul_out_value", 32'(out_value), 32'h0033);
    tick();
    drive(1'b0, 0, 0, 0, 1'b1, 3, 16'h0033, 3);
    check_model();
    tick();

    // WAW on r4, then asynchronous reset in the middle of the stall.
    drive(1'b1, 4, 0, 0, 1'b0, 0, 16'h0000, 3);
    check_model();
    tick();
    drive(1'b1, 4, 0, 0, 1'b0, 0, 16'h0000, 3);
    check_model();
    chk("waw_stall", 32'(stall), 32'd1);
    chk("waw_busy_count", 32'(busy_count), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    chk("midreset_stall", 32'(stall), 32'd0);
    chk("midreset_busy_count", 32'(busy_count), 32'd0);
    chk("midreset_out_value", 32'(out_value), 32'h0000);
    @(posedge CLK);
    #1;
    chk("midreset_hold_busy_count", 32'(busy_count), 32'd0);
    RST = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0, 0, 16'h0000, 0);
    check_model();
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            16'($urandom), int'($urandom_range(0, 7)));
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
